// File: rtl/io_map_pkg.sv
// IO address map shared by the load- and store-side decoders.
package io_map_pkg;

  localparam logic [5:0] ADDR_UART_RX = 6'd32;
  localparam logic [5:0] ADDR_UART_ST = 6'd33;
  localparam logic [5:0] ADDR_LEDS    = 6'd40;
  localparam logic [5:0] ADDR_SW      = 6'd41;
  localparam logic [5:0] ADDR_BTN     = 6'd42;
  localparam logic [5:0] ADDR_7SEG    = 6'd43;

  typedef enum logic [2:0] {
    SEL_MEM, SEL_RX, SEL_RXST, SEL_SW, SEL_BTN, SEL_ZERO
  } io_sel_t;

  // LEDs and 7-seg are write-only, so they read back as zero.
  function automatic io_sel_t io_sel_decode(input logic [5:0] addr);
    if (!addr[5]) return SEL_MEM;
    case (addr)
      ADDR_UART_RX: return SEL_RX;
      ADDR_UART_ST: return SEL_RXST;
      ADDR_SW:      return SEL_SW;
      ADDR_BTN:     return SEL_BTN;
      default:      return SEL_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Per-bit 2-FF synchroniser followed by a stability counter; the accepted
// level only moves after the synced bit has disagreed for CYCLES samples.
module sync_debounce #(
  parameter int WIDTH  = 16,
  parameter int CYCLES = 50_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic          s1, s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1       <= 1'b0;
        s2       <= 1'b0;
        cnt      <= '0;
        level[i] <= 1'b0;
      end else begin
        s1 <= raw[i];
        s2 <= s1;
        if (s2 == level[i]) begin
          cnt <= '0;
        end else if (cnt == CW'(CYCLES - 1)) begin
          level[i] <= s2;
          cnt      <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/io_read_controller.sv
// CPU load path for data memory, switches, buttons and UART RX; one word
// per cycle with a registered result one cycle after the load strobe.
module io_read_controller
  import io_map_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50_000,
  parameter int RX_FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r_enable,
  input  logic [5:0]  addr,
  input  logic [31:0] data_mem_in,
  input  logic [15:0] switches_raw,
  input  logic [4:0]  buttons_raw,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic [31:0] data_out,
  output logic        rd_valid,
  output logic        rx_not_empty
);

  localparam int PW     = $clog2(RX_FIFO_DEPTH);
  localparam int CW     = PW + 1;
  localparam int STAGES = 1;

  logic [15:0] sw_db;
  logic [4:0]  btn_db, btn_db_q, press_flags;

  sync_debounce #(.WIDTH(16), .CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
    .clk(clk), .rst_n(rst_n), .raw(switches_raw), .level(sw_db)
  );
  sync_debounce #(.WIDTH(5), .CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
    .clk(clk), .rst_n(rst_n), .raw(buttons_raw), .level(btn_db)
  );

  logic [RX_FIFO_DEPTH-1:0][7:0] fifo_mem;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          ovf;

  io_sel_t sel, sel_q;
  logic    rd_rx, rd_st, rd_btn, fifo_empty, fifo_full, pop, push;
  logic [31:0] io_word, io_q;
  logic [STAGES:0] vld_pipe;

  assign sel        = io_sel_decode(addr);
  assign rd_rx      = r_enable && (sel == SEL_RX);
  assign rd_st      = r_enable && (sel == SEL_RXST);
  assign rd_btn     = r_enable && (sel == SEL_BTN);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(RX_FIFO_DEPTH));
  assign pop        = rd_rx && !fifo_empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push       = uart_rx_valid && (!fifo_full || pop);
  assign rx_not_empty = !fifo_empty;

  // Side-effecting sources are captured before their pop/clear takes effect.
  always_comb begin
    io_word = '0;
    case (sel)
      SEL_RX:   if (!fifo_empty) io_word = {22'b0, ovf, 1'b1, fifo_mem[rd_ptr]};
      SEL_RXST: io_word = 32'({count, ovf});
      SEL_SW:   io_word = {16'b0, sw_db};
      SEL_BTN:  io_word = {11'b0, press_flags, 11'b0, btn_db};
      default:  io_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      sel_q    <= SEL_ZERO;
      io_q     <= '0;
      data_out <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], r_enable};
      if (r_enable) begin
        sel_q <= sel;
        io_q  <= io_word;
      end
      if (vld_pipe[0]) data_out <= (sel_q == SEL_MEM) ? data_mem_in : io_q;
    end
  end

  assign rd_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= uart_rx_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (uart_rx_valid && !push) ovf <= 1'b1;
      else if (rd_st)             ovf <= 1'b0;
    end
  end

  // A press arriving in the same cycle as the clearing read survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db_q    <= '0;
      press_flags <= '0;
    end else begin
      btn_db_q    <= btn_db;
      press_flags <= (rd_btn ? 5'b0 : press_flags) | (btn_db & ~btn_db_q);
    end
  end

endmodule

// File: tb/tb_io_read_controller.sv
// Directed bench for io_read_controller with a short debounce window.
module tb_io_read_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r_enable;
  logic [5:0]  addr;
  logic [31:0] data_mem_in;
  logic [15:0] switches_raw;
  logic [4:0]  buttons_raw;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic [31:0] data_out;
  logic        rd_valid;
  logic        rx_not_empty;

  int checks = 0;
  int failures = 0;

  io_read_controller #(.DEBOUNCE_CYCLES(4), .RX_FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .r_enable(r_enable), .addr(addr),
    .data_mem_in(data_mem_in), .switches_raw(switches_raw),
    .buttons_raw(buttons_raw), .uart_rx_data(uart_rx_data),
    .uart_rx_valid(uart_rx_valid), .data_out(data_out),
    .rd_valid(rd_valid), .rx_not_empty(rx_not_empty)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One load: strobe for a single edge, then step to the result edge.
  task automatic do_read(input logic [5:0] a);
    r_enable = 1'b1; addr = a;
    tick(1);
    r_enable = 1'b0;
    tick(1);
  endtask

  task automatic push(input logic [7:0] b);
    uart_rx_valid = 1'b1; uart_rx_data = b;
    tick(1);
    uart_rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; r_enable = 1'b0; addr = '0; data_mem_in = '0;
    switches_raw = '0; buttons_raw = '0; uart_rx_data = '0; uart_rx_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      switches_raw = 16'($urandom); buttons_raw = 5'($urandom);
      uart_rx_valid = i[0]; r_enable = ~i[0]; addr = 6'd32;
      tick(1);
    end
    checks++;
    if (data_out !== 32'h0 || rd_valid !== 1'b0 || rx_not_empty !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold data_out=%h rd_valid=%b rx_not_empty=%b required 0/0/0",
               data_out, rd_valid, rx_not_empty);
    end
    switches_raw = '0; buttons_raw = '0; uart_rx_valid = 1'b0; r_enable = 1'b0;
    #1 rst_n = 1'b1;
    tick(2);
    checks++;
    if (data_out !== 32'h0 || rd_valid !== 1'b0 || rx_not_empty !== 1'b0) begin
      failures++;
      $display("FAIL reset_release data_out=%h rd_valid=%b rx_not_empty=%b required 0/0/0",
               data_out, rd_valid, rx_not_empty);
    end
  endtask

  task automatic test_switches;
    switches_raw = 16'hA5C3;
    tick(8);
    do_read(6'd41);
    checks++;
    if (rd_valid !== 1'b1 || data_out !== 32'h0000A5C3) begin
      failures++;
      $display("FAIL sw_read data_out=%h rd_valid=%b required 0000a5c3/1", data_out, rd_valid);
    end
    tick(1);
    checks++;
    if (rd_valid !== 1'b0 || data_out !== 32'h0000A5C3) begin
      failures++;
      $display("FAIL sw_hold data_out=%h rd_valid=%b required 0000a5c3/0", data_out, rd_valid);
    end
    switches_raw = 16'h0;
    tick(2);
    switches_raw = 16'hA5C3;
    tick(8);
    do_read(6'd41);
    checks++;
    if (data_out !== 32'h0000A5C3) begin
      failures++;
      $display("FAIL sw_glitch data_out=%h required 0000a5c3", data_out);
    end
  endtask

  task automatic test_buttons;
    buttons_raw = 5'b00100;
    tick(6);
    buttons_raw = 5'b0;
    tick(10);
    do_read(6'd42);
    checks++;
    if (data_out !== 32'h00040000) begin
      failures++;
      $display("FAIL btn_press data_out=%h required 00040000", data_out);
    end
    do_read(6'd42);
    checks++;
    if (data_out !== 32'h0) begin
      failures++;
      $display("FAIL btn_cleared data_out=%h required 00000000", data_out);
    end
  endtask

  task automatic test_rx_fifo;
    push(8'h41);
    push(8'h42);
    do_read(6'd32);
    checks++;
    if (data_out !== 32'h141 || rx_not_empty !== 1'b1) begin
      failures++;
      $display("FAIL rx_pop1 data_out=%h ne=%b required 00000141/1", data_out, rx_not_empty);
    end
    do_read(6'd32);
    checks++;
    if (data_out !== 32'h142 || rx_not_empty !== 1'b0) begin
      failures++;
      $display("FAIL rx_pop2 data_out=%h ne=%b required 00000142/0", data_out, rx_not_empty);
    end
    do_read(6'd32);
    checks++;
    if (data_out !== 32'h0) begin
      failures++;
      $display("FAIL rx_empty data_out=%h required 00000000", data_out);
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    do_read(6'd33);
    checks++;
    if (data_out !== 32'h9) begin
      failures++;
      $display("FAIL ovf_status data_out=%h required 00000009", data_out);
    end
    do_read(6'd33);
    checks++;
    if (data_out !== 32'h8) begin
      failures++;
      $display("FAIL ovf_cleared data_out=%h required 00000008", data_out);
    end
  endtask

  task automatic test_full_push_pop;
    logic [31:0] exp_drain [4];
    logic [5:0]  zero_addr [3];
    exp_drain = '{32'h111, 32'h112, 32'h113, 32'h155};
    zero_addr = '{6'd40, 6'd43, 6'd63};
    uart_rx_valid = 1'b1; uart_rx_data = 8'h55; r_enable = 1'b1; addr = 6'd32;
    tick(1);
    uart_rx_valid = 1'b0; r_enable = 1'b0;
    tick(1);
    checks++;
    if (data_out !== 32'h110) begin
      failures++;
      $display("FAIL full_pushpop data_out=%h required 00000110", data_out);
    end
    do_read(6'd33);
    checks++;
    if (data_out !== 32'h8) begin
      failures++;
      $display("FAIL full_status data_out=%h required 00000008", data_out);
    end
    for (int i = 0; i < 3; i++) begin
      do_read(zero_addr[i]);
      checks++;
      if (data_out !== 32'h0) begin
        failures++;
        $display("FAIL zero_addr_%0d data_out=%h required 00000000", zero_addr[i], data_out);
      end
    end
    data_mem_in = 32'hDEADBEEF;
    do_read(6'd5);
    checks++;
    if (data_out !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL mem_read data_out=%h required deadbeef", data_out);
    end
    for (int i = 0; i < 4; i++) begin
      do_read(6'd32);
      checks++;
      if (data_out !== exp_drain[i]) begin
        failures++;
        $display("FAIL drain_%0d data_out=%h required %h", i, data_out, exp_drain[i]);
      end
    end
    checks++;
    if (rx_not_empty !== 1'b0) begin
      failures++;
      $display("FAIL drain_empty ne=%b required 0", rx_not_empty);
    end
  endtask

  task automatic test_empty_push_read;
    uart_rx_valid = 1'b1; uart_rx_data = 8'h77; r_enable = 1'b1; addr = 6'd32;
    tick(1);
    uart_rx_valid = 1'b0; r_enable = 1'b0;
    tick(1);
    checks++;
    if (data_out !== 32'h0 || rx_not_empty !== 1'b1) begin
      failures++;
      $display("FAIL empty_pushread data_out=%h ne=%b required 00000000/1", data_out, rx_not_empty);
    end
    do_read(6'd32);
    checks++;
    if (data_out !== 32'h177) begin
      failures++;
      $display("FAIL empty_retained data_out=%h required 00000177", data_out);
    end
  endtask

  task automatic test_back_to_back;
    r_enable = 1'b1; addr = 6'd41;
    tick(1);
    addr = 6'd5;
    tick(1);
    r_enable = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || data_out !== 32'h0000A5C3) begin
      failures++;
      $display("FAIL b2b_first data_out=%h rd_valid=%b required 0000a5c3/1", data_out, rd_valid);
    end
    tick(1);
    checks++;
    if (rd_valid !== 1'b1 || data_out !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL b2b_second data_out=%h rd_valid=%b required deadbeef/1", data_out, rd_valid);
    end
    tick(1);
    checks++;
    if (rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle rd_valid=%b required 0", rd_valid);
    end
  endtask

  task automatic test_reset_mid_op;
    push(8'h99);
    r_enable = 1'b1; addr = 6'd5;
    tick(1);
    r_enable = 1'b0;
    rst_n = 1'b0;
    tick(1);
    checks++;
    if (rd_valid !== 1'b0 || data_out !== 32'h0 || rx_not_empty !== 1'b0) begin
      failures++;
      $display("FAIL reset_midop data_out=%h rd_valid=%b ne=%b required 0/0/0",
               data_out, rd_valid, rx_not_empty);
    end
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    test_reset();
    test_switches();
    test_buttons();
    test_rx_fifo();
    test_overflow();
    test_full_push_pop();
    test_empty_push_read();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
